// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper and
// the line defaults used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_CLK_FREQ_DEF   = 50_000_000;
  localparam int UART_BAUD_DEF       = 115_200;
  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clocks per oversample tick, truncated; callers need a result of 2 or more.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ_DEF,
  parameter int BAUD_RATE  = UART_BAUD_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Wrap counter 0..DIV-1; never stops, so tick phase is unrelated to rx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: LSB-first frames, oversampled start detect and mid-bit
// sampling, valid/ready output with frame / parity / overrun status.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ_DEF,
  parameter int BAUD_RATE  = UART_BAUD_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_meta, rx_s;
  rx_state_t            state, state_d;
  logic [SW-1:0]        s_cnt, s_cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic                 armed, armed_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 done;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic                 par_mis, par_mis_d;
`endif

  uart_rx_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to line-idle so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM and sampling counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_cnt   <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_mis <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      s_cnt   <= s_cnt_d;
      bit_cnt <= bit_cnt_d;
      armed   <= armed_d;
      shreg   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_mis <= par_mis_d;
`endif
    end
  end

  // Next-state logic; everything advances only on the oversample tick.
  // armed is only set in IDLE so a held-low line (break, or low across
  // reset release) must go high before another start is accepted.
  always_comb begin
    state_d   = state;
    s_cnt_d   = s_cnt;
    bit_cnt_d = bit_cnt;
    armed_d   = armed;
    shreg_d   = shreg;
    done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d = par_mis;
`endif
    if (tick) begin
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_d = START;
            s_cnt_d = '0;
            armed_d = 1'b0;
          end else if (rx_s) begin
            armed_d = 1'b1;
          end
        end
        START: begin
          if (s_cnt == S_MID) begin
            if (!rx_s) begin
              state_d   = DATA;
              s_cnt_d   = '0;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;  // start bit not low at its centre: glitch
            end
          end else begin
            s_cnt_d = s_cnt + 1'b1;
          end
        end
        DATA: begin
          if (s_cnt == S_END) begin
            shreg_d   = {rx_s, shreg[DATA_BITS-1:1]};
            s_cnt_d   = '0;
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            s_cnt_d = s_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_cnt == S_END) begin
            par_mis_d = ((^shreg) ^ rx_s) != ODD;
            s_cnt_d   = '0;
            state_d   = STOP;
          end else begin
            s_cnt_d = s_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (s_cnt == S_END) begin
            done    = 1'b1;
            s_cnt_d = '0;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output word register; a completing word wins over acceptance, and an
  // accept in the same cycle means the old word was taken (no overrun).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      rx_data     <= shreg;
      rx_valid    <= 1'b1;
      frame_err   <= !rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err  <= par_mis;
`else
      // PARITY_ODD has no effect without the parity bit.
      parity_err  <= 1'b0 & (PARITY_ODD != 0);
`endif
      overrun_err <= rx_valid && !rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
